wb_ram_arb_b3: RTL and testbench
================================

# wb_ram_arb_b3

Round-robin Wishbone B3 arbiter that shares one Wishbone slave (the on-chip RAM) between `NM` masters, e.g. the OR1K data port and the debug unit's bus master. It grants the slave to one master for a whole `cyc` period, so classic and incrementing/wrapping bursts are never interleaved. It also returns a bus error on any strobe the slave leaves unanswered for too long. It sits between the masters' Wishbone ports and the RAM's slave port in the PU-OR1K bench.

## Interface
Parameters:
- `DW`, 32: data width.
- `AW`, 32: address width.
- `NM`, 2: number of masters (≥2). Master buses are packed, with master `i` in slice `[i*W +: W]`.
- `TIMEOUT`, 255: cycles of unanswered strobe before a synthesized error. 0 disables the timeout.

Ports:
- `wb_clk_i` in 1: clock; all logic on the rising edge.
- `wb_rst_i` in 1: reset, synchronous, active-low.
- `m_adr_i` in NM*AW, `m_dat_i` in NM*DW, `m_sel_i` in NM*4, `m_we_i` in NM, `m_bte_i` in NM*2, `m_cti_i` in NM*3, `m_cyc_i` in NM, `m_stb_i` in NM: master requests.
- `m_ack_o`, `m_err_o`, `m_rty_o` out NM: per-master responses.
- `m_dat_o` out DW: slave read data, broadcast to all masters.
- `s_adr_o` out AW, `s_dat_o` out DW, `s_sel_o` out 4, `s_we_o` out 1, `s_bte_o` out 2, `s_cti_o` out 3, `s_cyc_o` out 1, `s_stb_o` out 1: to the slave.
- `s_ack_i`, `s_err_i`, `s_rty_i` in 1, `s_dat_i` in DW: from the slave.
- `grant_o` out NM: one-hot current grant; all zero when idle.

## Operation
- State machine `IDLE` / `BUSY`. A registered grant index `gnt` and a round-robin pointer `last` (index of the most recent grant).
- `IDLE`: if any `m_cyc_i` is high, the arbiter grants the first requester found searching `last+1, last+2, …` modulo NM. It moves to `BUSY` and sets `last` to the granted index.
- `BUSY`: the grant is held while `m_cyc_i[gnt]` stays high, regardless of `cti`/`bte`, stalls or other requests.
- `BUSY`, when `m_cyc_i[gnt]` is low at an edge:
  - if another master requests, the arbiter grants the next requester by round-robin and stays `BUSY`;
  - otherwise it goes to `IDLE`.
  - The releasing master is the lowest priority in this search; it is re-granted only if it is the sole requester.
- Slave outputs equal the granted master's inputs through a combinational mux on the `gnt` register. When idle, every `s_*_o` is 0.
- `m_ack_o[gnt]` = `s_ack_i`, and `m_rty_o[gnt]` = `s_rty_i`. `m_err_o[gnt]` = `s_err_i | to_err`. Non-granted masters see 0 on ack, err and rty.
- Timeout counter, width `$clog2(TIMEOUT+1)`:
  - It clears when the slave is idle, or when `s_ack_i`, `s_err_i` or `s_rty_i` is high.
  - Otherwise it increments while `s_cyc_o & s_stb_o`.
  - `to_err` is asserted for exactly one cycle when the count equals `TIMEOUT`; the counter clears on that cycle.
  - The grant is unaffected by `to_err`; the master ends its own cycle.

## Timing
- Reset (`wb_rst_i`=0 at an edge): state `IDLE`, `grant_o`=0, `last`=NM-1 (so master 0 is preferred first), counter 0. All `s_*_o` and `m_ack/err/rty_o` are 0 in the following cycle.
- Reset in the middle of a burst drops `s_cyc_o` in the next cycle. The slave's in-flight ack is not forwarded to any master.
- Arbitration latency: `m_cyc_i` rising in cycle N gives `s_cyc_o` high from cycle N+1 when the bus is idle.
- Handover: the owner drops `cyc` in cycle N, `s_cyc_o` is low in N, and the new owner is on the bus in N+1. This guarantees at least one idle cycle between masters.
- Response paths (slave to master) are purely combinational, with zero added latency. This keeps the RAM's registered-feedback bursts at one beat per cycle.
- If all masters raise `cyc` in the same cycle, round-robin order from `last` decides the winner.

## Structure
- Package `wb_arb_pkg` holds:
  - the state enum `arb_state_t` (`IDLE`, `BUSY`);
  - CTI constants `CTI_CLASSIC`=3'b000, `CTI_CONST`=3'b001, `CTI_INCR`=3'b010, `CTI_EOB`=3'b111;
  - BTE constants `BTE_LINEAR`, `BTE_WRAP4`, `BTE_WRAP8`, `BTE_WRAP16`.
- One sub-module, `wb_rr_picker`: combinational. Inputs are the request vector `req[NM]` and `last`; outputs are `valid` and the next index. It is reused by both the `IDLE` and `BUSY`-handover paths.

## Test plan
- Reset, then master 0 does a classic write of 0xDEADBEEF to 0x100 followed by a read. Required: grant 0 from cycle 1, the read returns 0xDEADBEEF, and master 1 sees no ack.
- Both masters raise `cyc` in the same cycle. Required: master 0 is granted first; master 1 is granted in the cycle after master 0 drops `cyc`, with a one-cycle `s_cyc_o` gap.
- Master 1 performs an 8-beat `CTI_INCR` wrap burst while master 0 requests. Required: all 8 acks reach master 1 back-to-back, and master 0 is granted only after `cti`=111 and master 1's `cyc` drops.
- Slave stub never acks, with `TIMEOUT`=4. Required: `m_err_o[gnt]` pulses exactly once, 4 cycles after `stb` rises, and pulses again 5 cycles later if `stb` is held.
- Reset asserted mid-burst. Required: `s_cyc_o`=0 and `grant_o`=0 in the next cycle, and master 0 wins the first grant after reset.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone B3 cycle/burst encodings for the RAM arbiter.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extensions
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin requester search: first asserted req starting at last+1 (mod NM).
// The index equal to last is examined last, so it only wins when alone.
module wb_rr_picker #(
  parameter int unsigned NM = 2,
  parameter int unsigned LW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [LW-1:0] last_i,
  output logic          valid_o,
  output logic [LW-1:0] idx_o
);

  // Scan the NM candidates in rotated order and keep the first hit
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 1; k <= NM; k++) begin
      int unsigned cand;
      cand = (32'(last_i) + k) % NM;
      if (!valid_o && req_i[cand[LW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[LW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_ram_arb_b3.sv
// Round-robin Wishbone B3 arbiter sharing one slave (on-chip RAM) among NM
// masters. Ownership lasts a whole cyc period; unanswered strobes get a
// synthesized bus error after TIMEOUT cycles.
module wb_ram_arb_b3
  import wb_arb_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned NM      = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*2-1:0]  m_bte_i,
  input  logic [NM*3-1:0]  m_cti_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NM-1:0]    m_rty_o,
  output logic [DW-1:0]    m_dat_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic [1:0]       s_bte_o,
  output logic [2:0]       s_cti_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  input  logic [DW-1:0]    s_dat_i,
  output logic [NM-1:0]    grant_o
);

  localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t    state_q, state_d;
  logic [LW-1:0] gnt_q, gnt_d;
  logic [LW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_valid;
  logic [LW-1:0] pick_idx;
  logic          busy;
  logic          to_err;

  assign busy = (state_q == BUSY);

  // While BUSY, last_q always equals gnt_q, so one picker seeded with last_q
  // serves both the idle grant and the handover (releaser searched last).
  wb_rr_picker #(
    .NM (NM),
    .LW (LW)
  ) u_picker (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Next-state logic: grant on request, hold for the whole cyc, hand over on release
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          gnt_d   = pick_idx;
          last_d  = pick_idx;
        end
      end
      BUSY: begin
        if (!m_cyc_i[gnt_q]) begin
          if (pick_valid) begin
            gnt_d  = pick_idx;
            last_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request path: mux the granted master onto the slave port, zero when idle
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_bte_o = '0;
    s_cti_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (busy && (gnt_q == LW'(i))) begin
        s_adr_o = m_adr_i[i*AW +: AW];
        s_dat_o = m_dat_i[i*DW +: DW];
        s_sel_o = m_sel_i[i*4 +: 4];
        s_we_o  = m_we_i[i];
        s_bte_o = m_bte_i[i*2 +: 2];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_cyc_o = m_cyc_i[i];
        s_stb_o = m_stb_i[i];
      end
    end
  end

  assign to_err  = (TIMEOUT != 0) && s_cyc_o && s_stb_o && (cnt_q == CW'(TIMEOUT));
  assign m_dat_o = s_dat_i;

  // Response path: route slave responses to the granted master only
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    grant_o = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (busy && (gnt_q == LW'(i))) begin
        m_ack_o[i] = s_ack_i;
        m_err_o[i] = s_err_i | to_err;
        m_rty_o[i] = s_rty_i;
        grant_o[i] = 1'b1;
      end
    end
  end

  // Timeout counter: counts unanswered strobe cycles, restarts after each error pulse
  always_comb begin
    cnt_d = cnt_q;
    if (TIMEOUT == 0) begin
      cnt_d = '0;
    end else if (!s_cyc_o || s_ack_i || s_err_i || s_rty_i || to_err) begin
      cnt_d = '0;
    end else if (s_stb_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_ram_arb_b3.sv
// Self-checking bench for wb_ram_arb_b3: two masters, a zero-wait RAM stub
// with switchable ack, and a read-data scoreboard.
module tb_wb_ram_arb_b3;
  import wb_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NM = 2;
  localparam int unsigned TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [DW-1:0]    m_dat_o, s_dat_o, s_dat_i;
  logic [AW-1:0]    s_adr_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
  logic [1:0]       s_bte_o;
  logic [2:0]       s_cti_o;

  logic [31:0] madr [NM];
  logic [31:0] mdat [NM];
  logic [3:0]  msel [NM];
  logic [2:0]  mcti [NM];
  logic [1:0]  mbte [NM];
  logic        mwe  [NM];
  logic        mcyc [NM];
  logic        mstb [NM];

  logic [31:0] mem [256];
  logic        ack_en = 1'b1;
  logic [31:0] exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  assign m_adr_i = {madr[1], madr[0]};
  assign m_dat_i = {mdat[1], mdat[0]};
  assign m_sel_i = {msel[1], msel[0]};
  assign m_cti_i = {mcti[1], mcti[0]};
  assign m_bte_i = {mbte[1], mbte[0]};
  assign m_we_i  = {mwe[1], mwe[0]};
  assign m_cyc_i = {mcyc[1], mcyc[0]};
  assign m_stb_i = {mstb[1], mstb[0]};

  // Zero-wait RAM stub: combinational ack and read data
  assign s_ack_i = ack_en & s_cyc_o & s_stb_o;
  assign s_err_i = 1'b0;
  assign s_rty_i = 1'b0;
  assign s_dat_i = mem[s_adr_o[9:2]];

  always #5 clk = ~clk;

  wb_ram_arb_b3 #(
    .DW      (DW),
    .AW      (AW),
    .NM      (NM),
    .TIMEOUT (TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_sel_i  (m_sel_i),
    .m_we_i   (m_we_i),
    .m_bte_i  (m_bte_i),
    .m_cti_i  (m_cti_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_rty_o  (m_rty_o),
    .m_dat_o  (m_dat_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_bte_o  (s_bte_o),
    .s_cti_o  (s_cti_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .s_dat_i  (s_dat_i),
    .grant_o  (grant_o)
  );

  function automatic logic [31:0] pat(input int unsigned idx);
    return 32'hC0DE0000 + idx;
  endfunction

  function automatic logic [31:0] wrap_adr(input int unsigned k);
    return 32'h200 | ((32'h08 + 32'(4 * k)) & 32'h1C);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM stub write port
  always @(posedge clk) begin
    if (s_ack_i && s_we_o) mem[s_adr_o[9:2]] <= s_dat_o;
  end

  // Scoreboard: every read ack is compared against the oldest expected word
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NM; i++) begin
        if (m_ack_o[i] && !mwe[i]) begin
          if (exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
          else check("rd_data", 64'(m_dat_o), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic idle_master(input int m);
    madr[m] = '0; mdat[m] = '0; msel[m] = '0; mcti[m] = CTI_CLASSIC;
    mbte[m] = BTE_LINEAR; mwe[m] = 1'b0; mcyc[m] = 1'b0; mstb[m] = 1'b0;
  endtask

  task automatic drive(input int m, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [2:0] cti, input logic [1:0] bte);
    madr[m] = adr; mdat[m] = dat; msel[m] = 4'hF; mwe[m] = we;
    mcti[m] = cti; mbte[m] = bte; mcyc[m] = 1'b1; mstb[m] = 1'b1;
  endtask

  // Single classic transfer; for reads, dat is the expected word
  task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input bit lat);
    bit got;
    @(posedge clk); #1;
    drive(m, we, adr, (we ? dat : 32'h0), CTI_CLASSIC, BTE_LINEAR);
    if (!we) exp_q.push_back(dat);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (lat && i == 0) check("lat_idle", 64'(grant_o), 64'd0);
      if (lat && i == 1) check("lat_grant", 64'(grant_o), 64'(1 << m));
      check("no_ack_other", 64'(m_ack_o[1-m]), 64'd0);
      if (m_ack_o[m]) got = 1'b1;
    end
    check("xfer_done", 64'(got), 64'd1);
    @(posedge clk); #1;
    idle_master(m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    idle_master(0);
    idle_master(1);

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_scyc", 64'(s_cyc_o), 64'd0);
    check("rst_resp", 64'({m_ack_o, m_err_o, m_rty_o}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Classic write then read by master 0
    xfer(0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
    xfer(0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);
    // Master 1 read moves the round-robin pointer to 1 so master 0 wins the tie
    xfer(1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);

    // Simultaneous requests
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h300, 32'hAAAA0000, CTI_CLASSIC, BTE_LINEAR);
    drive(1, 1'b1, 32'h304, 32'hBBBB1111, CTI_CLASSIC, BTE_LINEAR);
    @(negedge clk);
    check("rr_idle", 64'(grant_o), 64'd0);
    @(negedge clk);
    check("rr_first", 64'(grant_o), 64'b01);
    check("rr_ack_m0", 64'(m_ack_o), 64'b01);
    @(posedge clk); #1;
    idle_master(0);
    @(negedge clk);
    check("rr_gap", 64'(s_cyc_o), 64'd0);
    @(negedge clk);
    check("rr_second", 64'(grant_o), 64'b10);
    check("rr_ack_m1", 64'(m_ack_o), 64'b10);
    @(posedge clk); #1;
    idle_master(1);
    xfer(0, 1'b0, 32'h300, 32'hAAAA0000, 1'b1);
    xfer(0, 1'b0, 32'h304, 32'hBBBB1111, 1'b1);

    // 8-beat wrap burst by master 1 while master 0 waits
    @(posedge clk); #1;
    drive(1, 1'b0, wrap_adr(0), 32'h0, CTI_INCR, BTE_WRAP8);
    exp_q.push_back(pat(wrap_adr(0) >> 2));
    @(negedge clk);
    check("burst_wait", 64'(grant_o), 64'd0);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h380, 32'h12345678, CTI_CLASSIC, BTE_LINEAR);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("burst_ack", 64'(m_ack_o), 64'b10);
      @(posedge clk); #1;
      if (k < 7) begin
        madr[1] = wrap_adr(k + 1);
        mcti[1] = (k + 1 == 7) ? CTI_EOB : CTI_INCR;
        exp_q.push_back(pat(wrap_adr(k + 1) >> 2));
      end else begin
        idle_master(1);
      end
    end
    @(negedge clk);
    check("burst_gap_scyc", 64'(s_cyc_o), 64'd0);
    check("burst_gap_grant", 64'(grant_o), 64'b10);
    @(negedge clk);
    check("burst_handover", 64'(grant_o), 64'b01);
    check("burst_m0_ack", 64'(m_ack_o), 64'b01);
    @(posedge clk); #1;
    idle_master(0);
    xfer(1, 1'b0, 32'h380, 32'h12345678, 1'b1);

    // Timeout: slave never answers
    ack_en = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h3F0, 32'h55AA55AA, CTI_CLASSIC, BTE_LINEAR);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("timeout_err_c%0d", c), 64'(m_err_o), 64'((c == 5 || c == 10) ? 2'b01 : 2'b00));
    end
    @(posedge clk); #1;
    idle_master(0);
    @(posedge clk); #1;
    ack_en = 1'b1;

    // Reset in the middle of a burst owned by master 1
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h3E0, 32'h0000E0E0, CTI_CLASSIC, BTE_LINEAR);
    drive(1, 1'b1, 32'h3C0, 32'h0000C0C0, CTI_INCR, BTE_LINEAR);
    @(negedge clk);
    @(negedge clk);
    check("mid_owner", 64'(grant_o), 64'b10);
    @(posedge clk); #1;
    madr[1] = 32'h3C4;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_scyc", 64'(s_cyc_o), 64'd0);
    check("mid_rst_grant", 64'(grant_o), 64'd0);
    check("mid_rst_ack", 64'(m_ack_o), 64'd0);
    @(negedge clk);
    check("post_rst_grant", 64'(grant_o), 64'b01);
    @(posedge clk); #1;
    idle_master(0);
    idle_master(1);
    repeat (3) @(posedge clk);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
